// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM between the CPU load/store path and a
// DMA/program-loader port. Each access is latched, strobed for one cycle,
// then acknowledged. The CPU has fixed priority. A starvation counter and a
// burst lock let the DMA make progress under continuous CPU traffic.
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_wen,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_wen,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  input  logic              i_dma_lock,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_ram_cen,
  output logic              o_ram_wen,
  output logic              o_ram_ren,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Saturation point of the starvation counter (MAX_WAIT is 1..15).
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t              state;
  logic                owner_dma;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [3:0]          wait_cnt;
  logic                lock;
  logic                cen_q;
  logic                wen_q;
  logic                ren_q;
  logic                cpu_ack_q;
  logic                dma_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dma_rdata_q;

  logic                grant_any;
  logic                grant_dma;
  logic                lock_hold;
  logic                starve;
  logic                sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration among the live requests; only acted on in S_IDLE.
  // The lock only holds while the DMA keeps asking for it, so a request
  // presented with i_dma_lock=0 already competes normally in that cycle.
  always_comb begin
    lock_hold = lock & i_dma_req & i_dma_lock;
    starve    = (wait_cnt == WAIT_MAX) & i_dma_req;
    grant_any = 1'b0;
    grant_dma = 1'b0;
    if (lock_hold || starve) begin
      grant_any = 1'b1;
      grant_dma = 1'b1;
    end else if (i_cpu_req) begin
      grant_any = 1'b1;
      grant_dma = 1'b0;
    end else if (i_dma_req) begin
      grant_any = 1'b1;
      grant_dma = 1'b1;
    end
    sel_wen   = grant_dma ? i_dma_wen   : i_cpu_wen;
    sel_addr  = grant_dma ? i_dma_addr  : i_cpu_addr;
    sel_wdata = grant_dma ? i_dma_wdata : i_cpu_wdata;
  end

  // Access FSM: latches the winning command, strobes the RAM for one cycle,
  // captures read data and pulses the owner's ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      owner_dma   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      wait_cnt    <= 4'd0;
      lock        <= 1'b0;
      cen_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_dma_req || !i_dma_lock) lock <= 1'b0;
          if (grant_any) begin
            owner_dma <= grant_dma;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cen_q     <= 1'b1;
            wen_q     <= sel_wen;
            ren_q     <= ~sel_wen;
            state     <= S_ACC;
            if (grant_dma) begin
              wait_cnt <= 4'd0;
              lock     <= i_dma_lock;
            end else if (i_dma_req && (wait_cnt != WAIT_MAX)) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        S_ACC: begin
          cen_q <= 1'b0;
          wen_q <= 1'b0;
          ren_q <= 1'b0;
          if (owner_dma) begin
            dma_ack_q <= 1'b1;
            if (ren_q) dma_rdata_q <= i_ram_rdata;
          end else begin
            cpu_ack_q <= 1'b1;
            if (ren_q) cpu_rdata_q <= i_ram_rdata;
          end
          state <= S_ACK;
        end
        S_ACK: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ram_cen   = cen_q;
  assign o_ram_wen   = wen_q;
  assign o_ram_ren   = ren_q;
  assign o_ram_addr  = cmd_addr;
  assign o_ram_wdata = cmd_wdata;
  assign o_cpu_ack   = cpu_ack_q;
  assign o_dma_ack   = dma_ack_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_dma_rdata = dma_rdata_q;
  assign o_cpu_stall = i_cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, single-port accesses, contention
// with the starvation counter, burst lock and reset during an access.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       cpu_ack, cpu_stall;
  logic [7:0] cpu_rdata;
  logic       dma_req = 1'b0, dma_wen = 1'b0, dma_lock = 1'b0;
  logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic       ram_cen, ram_wen, ram_ren;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // RAM model: read data is a fixed function of the address; writes are logged.
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr = 8'h00;
  logic [7:0] last_wr_data = 8'h00;
  assign ram_rdata = ram_addr ^ 8'hB7;

  always @(posedge clk) begin
    if (ram_cen && ram_wen) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= ram_addr;
      last_wr_data <= ram_wdata;
    end
  end

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_wen(cpu_wen), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_wen(dma_wen), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_lock(dma_lock),
    .o_dma_ack(dma_ack), .o_dma_rdata(dma_rdata),
    .o_ram_cen(ram_cen), .o_ram_wen(ram_wen), .o_ram_ren(ram_ren),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, dma_ack, ram_cen, ram_wen, ram_ren, cpu_stall} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000", {cpu_ack, dma_ack, ram_cen, ram_wen, ram_ren, cpu_stall});
    end
    n_cmp++;
    if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); end
    n_cmp++;
    if (dma_rdata !== 8'h00) begin n_err++; $display("FAIL reset_dma_rdata: got %h want 00", dma_rdata); end
    n_cmp++;
    if (ram_addr !== 8'h00) begin n_err++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
    n_cmp++;
    if (ram_wdata !== 8'h00) begin n_err++; $display("FAIL reset_ram_wdata: got %h want 00", ram_wdata); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h12;
    #1;
    n_cmp++;
    if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL cpu_rd_stall_t: got %b want 1", cpu_stall); end
    @(negedge clk);
    n_cmp++;
    if ({ram_cen, ram_ren, ram_wen} !== 3'b110) begin
      n_err++; $display("FAIL cpu_rd_strobes: got %b want 110", {ram_cen, ram_ren, ram_wen});
    end
    n_cmp++;
    if (ram_addr !== 8'h12) begin n_err++; $display("FAIL cpu_rd_addr: got %h want 12", ram_addr); end
    n_cmp++;
    if ({cpu_stall, cpu_ack} !== 2'b10) begin n_err++; $display("FAIL cpu_rd_stall_t1: got %b want 10", {cpu_stall, cpu_ack}); end
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_stall, dma_ack} !== 3'b100) begin
      n_err++; $display("FAIL cpu_rd_ack: got %b want 100", {cpu_ack, cpu_stall, dma_ack});
    end
    n_cmp++;
    if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL cpu_rd_data: got %h want a5", cpu_rdata); end
    n_cmp++;
    if ({ram_cen, ram_ren, ram_wen} !== 3'b000) begin
      n_err++; $display("FAIL cpu_rd_strobes_ack: got %b want 000", {ram_cen, ram_ren, ram_wen});
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_rdata} !== {1'b0, 8'hA5}) begin
      n_err++; $display("FAIL cpu_rd_hold: got ack %b data %h want ack 0 data a5", cpu_ack, cpu_rdata);
    end
  endtask

  task automatic test_dma_write();
    int wr0;
    wr0 = wr_cnt;
    dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if ({ram_cen, ram_wen, ram_ren} !== 3'b110) begin
      n_err++; $display("FAIL dma_wr_strobes: got %b want 110", {ram_cen, ram_wen, ram_ren});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata} !== {8'h40, 8'h3C}) begin
      n_err++; $display("FAIL dma_wr_bus: got %h/%h want 40/3c", ram_addr, ram_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({dma_ack, cpu_ack, ram_cen, ram_wen} !== 4'b1000) begin
      n_err++; $display("FAIL dma_wr_ack: got %b want 1000", {dma_ack, cpu_ack, ram_cen, ram_wen});
    end
    n_cmp++;
    if (dma_rdata !== 8'h00) begin n_err++; $display("FAIL dma_wr_rdata: got %h want 00", dma_rdata); end
    n_cmp++;
    if (cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL dma_wr_cpu_rdata: got %h want a5", cpu_rdata); end
    dma_req = 1'b0; dma_wen = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ((wr_cnt - wr0) != 1) begin n_err++; $display("FAIL dma_wr_count: got %0d want 1", wr_cnt - wr0); end
    n_cmp++;
    if ({last_wr_addr, last_wr_data} !== {8'h40, 8'h3C}) begin
      n_err++; $display("FAIL dma_wr_ram: got %h/%h want 40/3c", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_dma_read();
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 8'h33;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dma_ack, dma_rdata} !== {1'b1, 8'h84}) begin
      n_err++; $display("FAIL dma_rd: got ack %b data %h want ack 1 data 84", dma_ack, dma_rdata);
    end
    n_cmp++;
    if ({cpu_ack, cpu_rdata} !== {1'b0, 8'hA5}) begin
      n_err++; $display("FAIL dma_rd_cpu_side: got ack %b data %h want ack 0 data a5", cpu_ack, cpu_rdata);
    end
    dma_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic exp_order [10];
    logic got_order [10];
    int   n;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    n = 0;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h01;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 8'h02; dma_lock = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      @(negedge clk);
      if (cpu_ack) begin got_order[n] = 1'b0; n++; end
      if (dma_ack && n < 10) begin
        got_order[n] = 1'b1; n++;
        n_cmp++;
        if (dut.wait_cnt !== 4'd0) begin n_err++; $display("FAIL cont_cnt_clear: got %0d want 0", dut.wait_cnt); end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    n_cmp++;
    if (n != 10) begin
      n_err++; $display("FAIL cont_timeout: got %0d grants want 10", n);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (got_order[i] !== exp_order[i]) begin
          n_err++; $display("FAIL cont_grant%0d: got dma=%b want dma=%b", i, got_order[i], exp_order[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_burst_lock();
    logic exp_order [5];
    logic got_order [5];
    int   n;
    int   dma_n;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    n = 0; dma_n = 0;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 8'h05; dma_lock = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h01;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      if (dma_ack) begin
        got_order[n] = 1'b1; n++; dma_n++;
        if (dma_n >= 3) dma_lock = 1'b0;
      end
      if (cpu_ack && n < 5) begin got_order[n] = 1'b0; n++; end
    end
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    n_cmp++;
    if (n != 5) begin
      n_err++; $display("FAIL lock_timeout: got %0d grants want 5", n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got_order[i] !== exp_order[i]) begin
          n_err++; $display("FAIL lock_grant%0d: got dma=%b want dma=%b", i, got_order[i], exp_order[i]);
        end
      end
    end
    n_cmp++;
    if (dut.lock !== 1'b0) begin n_err++; $display("FAIL lock_cleared: got %b want 0", dut.lock); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 8'h12;
    @(negedge clk);
    n_cmp++;
    if ({ram_cen, ram_ren} !== 2'b11) begin n_err++; $display("FAIL rst_mid_pre: got %b want 11", {ram_cen, ram_ren}); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ram_cen, ram_ren, ram_wen} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_strobes: got %b want 000", {ram_cen, ram_ren, ram_wen});
    end
    n_cmp++;
    if ({cpu_rdata, dma_rdata} !== 16'h0000) begin
      n_err++; $display("FAIL rst_mid_rdata: got %h/%h want 00/00", cpu_rdata, dma_rdata);
    end
    n_cmp++;
    if (dut.state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", dut.state); end
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, dma_ack} !== 2'b00) begin n_err++; $display("FAIL rst_mid_ack: got %b want 00", {cpu_ack, dma_ack}); end
    cpu_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, dma_ack, ram_cen} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_after: got %b want 000", {cpu_ack, dma_ack, ram_cen});
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_dma_read();
    test_contention();
    test_burst_lock();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data RAM between the CPU controller's load/store path and a DMA/program-loader port. It sits between the requesters and the RAM's cen/wen/ren strobes. It serialises accesses through a three-state access FSM, gives the CPU fixed priority, and applies a starvation counter and a burst-lock so the DMA still makes progress. Each access is latched, strobed for exactly one cycle, then acknowledged with read data.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- MAX_WAIT, 4, consecutive lost arbitrations after which the DMA wins (range 1..15)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_cpu_req  in  1  CPU access request; held with its command until o_cpu_ack
- i_cpu_wen  in  1  1 = write, 0 = read
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wdata  in  DATA_W  CPU write data
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_rdata  out  DATA_W  read data, valid while o_cpu_ack=1, held afterwards
- o_cpu_stall  out  1  i_cpu_req & ~o_cpu_ack (combinational); the controller freezes its FSM on this
- i_dma_req, i_dma_wen, i_dma_addr, i_dma_wdata  in  1/1/ADDR_W/DATA_W  DMA equivalents
- i_dma_lock  in  1  DMA burst lock request, sampled at DMA grant
- o_dma_ack, o_dma_rdata  out  1/DATA_W  DMA equivalents
- o_ram_cen, o_ram_wen, o_ram_ren  out  1  RAM strobes
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data, valid during the ren cycle (asynchronous read)

## Operation
- States: S_IDLE, S_ACC, S_ACK. Registered owner flag: CPU or DMA.
- S_IDLE: arbitrate among the asserted requests.
  - On a grant, latch owner, wen, addr and wdata into command registers, then go to S_ACC.
  - With no requests, stay in S_IDLE.
- Arbitration, in priority order:
  - (1) lock flag set and i_dma_req → DMA.
  - (2) wait counter == MAX_WAIT and i_dma_req → DMA.
  - (3) i_cpu_req → CPU.
  - (4) i_dma_req → DMA.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each S_IDLE grant to the CPU while i_dma_req=1.
  - Clears on any DMA grant.
- Lock flag:
  - Set to i_dma_lock on each DMA grant.
  - Cleared on any S_IDLE cycle where i_dma_req=0 or i_dma_lock=0.
- S_ACC (1 cycle):
  - o_ram_cen=1, o_ram_addr and o_ram_wdata from the command registers.
  - Write: o_ram_wen=1, o_ram_ren=0. Read: o_ram_ren=1, o_ram_wen=0.
  - On exit, register i_ram_rdata into the owner's rdata register (reads only; writes leave it unchanged). Go to S_ACK.
- S_ACK (1 cycle): pulse the owner's ack; all RAM strobes 0. Go to S_IDLE.
- The non-owner's rdata register and ack are never disturbed.
- A requester deasserts req, or presents a new command, in the cycle after its ack. The arbiter never samples req during S_ACC or S_ACK.

## Timing
- Reset (async, immediate): state S_IDLE, counter 0, lock 0, command registers 0. All outputs 0, including both rdata registers. Reset during S_ACC or S_ACK aborts the access; no ack is issued.
- Latency: request high at rising edge t while in S_IDLE → strobes during cycle t+1 → ack during cycle t+2 → back in S_IDLE at cycle t+3.
- Peak throughput is one access per 3 cycles.
- RAM outputs are driven from registers/state only, so they are glitch-free. The strobes are 0 in every state except S_ACC.
- Simultaneous requests with counter < MAX_WAIT and lock clear: CPU wins, and the counter increments.
- A DMA request arriving during a CPU access is only seen at the next S_IDLE.

## Test plan
- Reset mid-access: assert i_rst during S_ACC → strobes drop immediately, no ack, rdata 0, state S_IDLE.
- CPU read alone: addr 0x12, RAM returns 0xA5 → ren=1 and addr 0x12 in cycle t+1; o_cpu_ack=1 and o_cpu_rdata=0xA5 in t+2; o_cpu_stall=1 in t and t+1.
- DMA write alone: addr 0x40, wdata 0x3C → cen=wen=1, addr 0x40, wdata 0x3C for exactly one cycle; o_dma_ack one cycle later; o_dma_rdata unchanged.
- Contention, MAX_WAIT=4: CPU and DMA requesting continuously → grant order CPU,CPU,CPU,CPU,DMA, repeating; counter back to 0 after each DMA grant.
- Burst lock: DMA with i_dma_lock=1 for 3 requests while the CPU requests continuously → 3 consecutive DMA accesses. Lock deasserted on the 4th request → the CPU wins next.
